// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and constants for the byte-serial adder sequencer.
//   state_e : sequencer states (IDLE, RUN, DONE)
//   BYTE_W  : width of the single shared adder slice
//   clog2   : ceiling log2, used to size the byte index
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BYTE_W = 8;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/add_seq_add8_rc.sv
// add8_rc: combinational 8-bit ripple-carry adder built from 1-bit full adders.
//   x, y : addends
//   cin  : carry into bit 0
//   f    : 8-bit sum
//   cout : carry out of bit 7
module add8_rc
    import add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    input  logic              cin,
    output logic [BYTE_W-1:0] f,
    output logic              cout
);

    logic [BYTE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign f[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[BYTE_W];

endmodule

// File: rtl/add_seq.sv
// add_seq: NBYTES-byte adder that reuses one 8-bit ripple-carry adder,
// processing one byte per cycle, least significant byte first.
//
// Optional feature macro: ADD_SEQ_SUB_EN adds the 'sub' port; sub=1 computes
// a - b as a + ~b + 1 (cin ignored, cout=1 means no borrow).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   a, b, cin [, sub]   : operands, sampled on the accepting edge only
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
module add_seq
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NBYTES-1:0]    a,
    input  logic [8*NBYTES-1:0]    b,
    input  logic                   cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NBYTES-1:0]    sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [W-1:0]      b_eff_s;
    logic              cin_eff_s;
    logic [BYTE_W-1:0] add_x_s;
    logic [BYTE_W-1:0] add_y_s;
    logic [BYTE_W-1:0] add_f_s;
    logic              add_co_s;

    // Effective operands: subtraction is folded into the stored B and carry.
    always_comb begin
`ifdef ADD_SEQ_SUB_EN
        if (sub) begin
            b_eff_s   = ~b;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b;
            cin_eff_s = cin;
        end
`else
        b_eff_s   = b;
        cin_eff_s = cin;
`endif
    end

    // Byte mux feeding the shared adder slice.
    always_comb begin
        add_x_s = a_q[idx_q*BYTE_W +: BYTE_W];
        add_y_s = b_q[idx_q*BYTE_W +: BYTE_W];
    end

    add8_rc u_add8 (
        .x    (add_x_s),
        .y    (add_y_s),
        .cin  (carry_q),
        .f    (add_f_s),
        .cout (add_co_s)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff_s;
                    carry_d = cin_eff_s;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = add_f_s;
                carry_d = add_co_s;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = add_co_s;
                    // Bit 7 of the final byte is the MSB of the full result.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_f_s[BYTE_W-1] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
